// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding a UART transmitter one frame at a time over a data/send/busy handshake.
// Optional feature: define UART_TXQ_CRLF_EN to expand each 8'h0A into 8'h0D, 8'h0A on the wire.
module uart_tx_queue #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_send,
  input  logic                  tx_busy,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow
);

  localparam int                    DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = 1;

  typedef enum logic [1:0] {IDLE, SEND, ARMED, DRAIN} state_t;

  state_t                state, state_next;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [7:0]            head, issue_byte;
  logic                  push, pop, issue;
`ifdef UART_TXQ_CRLF_EN
  logic                  cr_sent;
`endif

  assign empty    = (level == '0);
  assign full     = (level == LEVEL_FULL);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    pop        = 1'b0;
    issue_byte = head;
    case (state)
      IDLE: begin
        if (!empty && !tx_busy) begin
          issue      = 1'b1;
          pop        = 1'b1;
          state_next = SEND;
`ifdef UART_TXQ_CRLF_EN
          // LF goes out twice through here: first as an inserted CR, then itself.
          if (head == 8'h0A && !cr_sent) begin
            pop        = 1'b0;
            issue_byte = 8'h0D;
          end
`endif
        end
      end
      SEND:    state_next = ARMED;
      ARMED:   if (tx_busy) state_next = DRAIN;
      DRAIN:   if (!tx_busy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      tx_data  <= 8'h00;
      tx_send  <= 1'b0;
      overflow <= 1'b0;
`ifdef UART_TXQ_CRLF_EN
      cr_sent  <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      tx_send  <= issue;
      overflow <= in_valid && !in_ready;
      if (issue) tx_data <= issue_byte;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop) level <= level + LEVEL_ONE;
      else if (pop && !push) level <= level - LEVEL_ONE;
`ifdef UART_TXQ_CRLF_EN
      if (issue) cr_sent <= !pop;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a simple busy-for-N-cycles transmitter model.
module tb_uart_tx_queue;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_busy;
  logic [4:0] level;
  logic       empty;
  logic       full;
  logic       overflow;

  int         checks = 0;
  int         errors = 0;
  bit         model_en = 0;
  int         busy_len = 10;
  int         busy_cnt = 0;
  logic [7:0] got [$];

  uart_tx_queue #(.DEPTH_LOG2(4)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
    .level(level), .empty(empty), .full(full), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, log pulses and run the transmitter model.
  task automatic tick();
    @(negedge clock);
    if (tx_send) begin
      got.push_back(tx_data);
      check("send_while_busy", {31'd0, tx_busy}, 32'd0);
    end
    if (model_en) begin
      if (tx_send) begin
        tx_busy  = 1'b1;
        busy_cnt = busy_len;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) tx_busy = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    tick(); tick();
    reset = 1'b0;
    got.delete();
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int b;
    b = budget;
    while (got.size() < n && b > 0) begin
      tick();
      b--;
    end
    check("pulse_count", got.size(), n);
  endtask

  initial begin
    int i;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; tx_busy = 1'b0;
    tick();

    // Reset values
    do_reset();
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_tx_send", tx_send, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);

    // Single byte with transmitter idle: push edge, then issue on the following edge
    in_data = 8'h41; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("single_level", level, 1);
    check("single_empty", empty, 0);
    check("single_nosend_yet", tx_send, 0);
    tick();
    check("single_send", tx_send, 1);
    check("single_data", tx_data, 8'h41);
    check("single_level_after", level, 0);
    tick();
    check("single_send_end", tx_send, 0);
    check("single_hold", tx_data, 8'h41);

    // Ordering "ABC" with a 10-cycle busy transmitter
    do_reset();
    model_en = 1; busy_len = 10; busy_cnt = 0; tx_busy = 1'b0;
    in_valid = 1'b1; in_data = 8'h41; tick();
    check("abc_level1", level, 1);
    in_data = 8'h42; tick();
    check("abc_level2", level, 1);
    in_data = 8'h43; tick();
    check("abc_level3", level, 2);
    in_valid = 1'b0;
    wait_pulses(3, 200);
    check("abc_b0", got[0], 8'h41);
    check("abc_b1", got[1], 8'h42);
    check("abc_b2", got[2], 8'h43);
    repeat (15) tick();
    check("abc_drained", level, 0);
    check("abc_empty", empty, 1);

    // Fill to full with the transmitter held busy, then overflow
    model_en = 0; tx_busy = 1'b1;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1; in_data = 8'h10 + 8'(k);
      tick();
      check("fill_level", level, k + 1);
    end
    check("fill_full", full, 1);
    check("fill_in_ready", in_ready, 0);
    check("fill_no_ovf", overflow, 0);
    in_data = 8'hEE; tick();
    in_valid = 1'b0;
    check("ovf_pulse", overflow, 1);
    check("ovf_level", level, 16);
    tick();
    check("ovf_one_cycle", overflow, 0);
    got.delete();
    model_en = 1; busy_len = 3; busy_cnt = 0; tx_busy = 1'b0;
    wait_pulses(16, 400);
    for (int k = 0; k < 16; k++) check("fill_byte", got[k], 8'h10 + 8'(k));
    repeat (10) tick();
    check("fill_no_extra", got.size(), 16);

    // Wrap-around: 40 incrementing bytes through a 16-entry ring
    do_reset();
    busy_len = 2; busy_cnt = 0; tx_busy = 1'b0;
    i = 0;
    while (i < 40) begin
      if (in_ready) begin
        in_valid = 1'b1; in_data = 8'(8'h80 + i); i++;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    wait_pulses(40, 1000);
    for (int k = 0; k < 40; k++) check("wrap_byte", got[k], 8'h80 + 8'(k));

    // Reset while a frame is in progress with bytes queued
    repeat (10) tick();
    model_en = 0; tx_busy = 1'b1;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = 8'h30 + 8'(k); tick();
    end
    in_valid = 1'b0;
    check("mid_level_before", level, 5);
    reset = 1'b1; tick(); reset = 1'b0;
    check("mid_level", level, 0);
    check("mid_empty", empty, 1);
    check("mid_send", tx_send, 0);
    tick();
    tx_busy = 1'b0;
    got.delete();
    repeat (20) tick();
    check("mid_no_pulses", got.size(), 0);

    // Line-feed handling
    do_reset();
    model_en = 1; busy_len = 3; busy_cnt = 0; tx_busy = 1'b0;
    in_valid = 1'b1; in_data = 8'h61; tick();
    in_data = 8'h0A; tick();
    in_valid = 1'b0;
`ifdef UART_TXQ_CRLF_EN
    wait_pulses(3, 200);
    check("crlf_b0", got[0], 8'h61);
    check("crlf_b1", got[1], 8'h0D);
    check("crlf_b2", got[2], 8'h0A);
`else
    wait_pulses(2, 200);
    check("lf_b0", got[0], 8'h61);
    check("lf_b1", got[1], 8'h0A);
`endif
    repeat (20) tick();
    check("lf_level", level, 0);
`ifdef UART_TXQ_CRLF_EN
    check("crlf_total", got.size(), 3);
`else
    check("lf_total", got.size(), 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
